// File: rtl/node_pkg.sv
// Shared widths and the sequencer state encoding for the node controller.
package node_pkg;

   localparam int WORD_WIDTH = 16;
   localparam int ADDR_WIDTH = 11;
   localparam int MEM_DEPTH  = 2048;
   localparam int WD_WIDTH   = 13;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ICH  = 3'd1,
      ST_AGG  = 3'd2,
      ST_QUP  = 3'd3,
      ST_FIN  = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   function automatic logic is_engine_state(input state_e s);
      return (s == ST_ICH) || (s == ST_AGG) || (s == ST_QUP);
   endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; expired flags the last cycle a phase may wait.
module phase_watchdog
   import node_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clock,
   input  logic nrst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [WD_WIDTH-1:0] count_r;

   // Count cycles spent in the current phase; clear wins so a new phase starts at zero.
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         count_r <= {WD_WIDTH{1'b0}};
      end else if (clear) begin
         count_r <= {WD_WIDTH{1'b0}};
      end else if (run) begin
         count_r <= count_r + {{(WD_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = run && (count_r == LIMIT);

endmodule

// File: rtl/node_seq.sv
// Round sequencer: ICH -> (AGG) -> QUP -> FIN with a per-phase watchdog
// and a state-selected mux onto the shared node memory port.
module node_seq
   import node_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clock,
   input  logic                  nrst,
   input  logic                  start,
   output logic                  ich_en,
   input  logic                  ich_done,
   input  logic                  ich_forAggregation,
   input  logic [ADDR_WIDTH-1:0] ich_address,
   input  logic                  ich_wr_en,
   input  logic [WORD_WIDTH-1:0] ich_data_out,
   output logic                  agg_en,
   input  logic                  agg_done,
   input  logic [ADDR_WIDTH-1:0] agg_address,
   input  logic                  agg_wr_en,
   input  logic [WORD_WIDTH-1:0] agg_data_out,
   output logic                  qup_en,
   input  logic                  qup_done,
   input  logic [ADDR_WIDTH-1:0] qup_address,
   input  logic                  qup_wr_en,
   input  logic [WORD_WIDTH-1:0] qup_data_out,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_wr_en,
   output logic [WORD_WIDTH-1:0] mem_data_out,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic [2:0]            phase
);

   state_e state_r;
   state_e state_nx_s;
   logic   agg_req_r;
   logic   agg_req_nx_s;
   logic   timeout_err_r;
   logic   timeout_err_nx_s;
   logic   ich_en_r;
   logic   agg_en_r;
   logic   qup_en_r;
   logic   done_r;
   logic   busy_r;
   logic   wd_clear_s;
   logic   wd_run_s;
   logic   wd_expired_s;

   // Next-state decode; an engine's done beats a same-cycle watchdog expiry.
   always_comb begin
      state_nx_s       = state_r;
      agg_req_nx_s     = agg_req_r;
      timeout_err_nx_s = timeout_err_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_ICH;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ICH: begin
            if (ich_done) begin
               agg_req_nx_s = ich_forAggregation;
               state_nx_s   = ich_forAggregation ? ST_AGG : ST_QUP;
            end else if (wd_expired_s) begin
               state_nx_s       = ST_ERR;
               timeout_err_nx_s = 1'b1;
            end else begin
               state_nx_s = ST_ICH;
            end
         end
         ST_AGG: begin
            if (agg_done) begin
               state_nx_s = ST_QUP;
            end else if (wd_expired_s) begin
               state_nx_s       = ST_ERR;
               timeout_err_nx_s = 1'b1;
            end else begin
               state_nx_s = ST_AGG;
            end
         end
         ST_QUP: begin
            if (qup_done) begin
               state_nx_s = ST_FIN;
            end else if (wd_expired_s) begin
               state_nx_s       = ST_ERR;
               timeout_err_nx_s = 1'b1;
            end else begin
               state_nx_s = ST_QUP;
            end
         end
         ST_FIN: begin
            state_nx_s = ST_IDLE;
         end
         ST_ERR: begin
            if (start) begin
               timeout_err_nx_s = 1'b0;
               state_nx_s       = ST_ICH;
            end else begin
               state_nx_s = ST_ERR;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   assign wd_clear_s = is_engine_state(state_nx_s) && (state_nx_s != state_r);
   assign wd_run_s   = is_engine_state(state_r);

   // State register; enables and status are decoded from the next state so they track phase exactly.
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state_r       <= ST_IDLE;
         agg_req_r     <= 1'b0;
         timeout_err_r <= 1'b0;
         ich_en_r      <= 1'b0;
         agg_en_r      <= 1'b0;
         qup_en_r      <= 1'b0;
         done_r        <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         agg_req_r     <= agg_req_nx_s;
         timeout_err_r <= timeout_err_nx_s;
         ich_en_r      <= (state_nx_s == ST_ICH);
         agg_en_r      <= (state_nx_s == ST_AGG);
         qup_en_r      <= (state_nx_s == ST_QUP);
         done_r        <= (state_nx_s == ST_FIN);
         busy_r        <= is_engine_state(state_nx_s) || (state_nx_s == ST_FIN);
      end
   end

   phase_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock   (clock),
      .nrst    (nrst),
      .clear   (wd_clear_s),
      .run     (wd_run_s),
      .expired (wd_expired_s)
   );

   assign mem_address  = (state_r == ST_ICH) ? ich_address  :
                         (state_r == ST_AGG) ? agg_address  :
                         (state_r == ST_QUP) ? qup_address  : {ADDR_WIDTH{1'b0}};
   assign mem_wr_en    = (state_r == ST_ICH) ? ich_wr_en    :
                         (state_r == ST_AGG) ? agg_wr_en    :
                         (state_r == ST_QUP) ? qup_wr_en    : 1'b0;
   assign mem_data_out = (state_r == ST_ICH) ? ich_data_out :
                         (state_r == ST_AGG) ? agg_data_out :
                         (state_r == ST_QUP) ? qup_data_out : {WORD_WIDTH{1'b0}};

   assign ich_en      = ich_en_r;
   assign agg_en      = agg_en_r;
   assign qup_en      = qup_en_r;
   assign done        = done_r;
   assign busy        = busy_r;
   assign timeout_err = timeout_err_r;
   assign phase       = state_r;

endmodule

// File: tb/tb_node_seq.sv
// Directed bench for node_seq: per-cycle reference model plus literal round checks.
module tb_node_seq;

   localparam int TO = 16;

   logic        clock = 1'b0;
   logic        nrst  = 1'b0;
   logic        start = 1'b0;
   logic        ich_en, agg_en, qup_en;
   logic        ich_done = 1'b0, agg_done = 1'b0, qup_done = 1'b0;
   logic        ich_forAggregation = 1'b1;
   logic [10:0] ich_address = 11'h155, agg_address = 11'h2AA, qup_address = 11'h7FF;
   logic        ich_wr_en = 1'b1, agg_wr_en = 1'b0, qup_wr_en = 1'b1;
   logic [15:0] ich_data_out = 16'hBEEF, agg_data_out = 16'h1234, qup_data_out = 16'hCAFE;
   logic [10:0] mem_address;
   logic        mem_wr_en;
   logic [15:0] mem_data_out;
   logic        busy, done, timeout_err;
   logic [2:0]  phase;

   node_seq #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .nrst(nrst), .start(start),
      .ich_en(ich_en), .ich_done(ich_done), .ich_forAggregation(ich_forAggregation),
      .ich_address(ich_address), .ich_wr_en(ich_wr_en), .ich_data_out(ich_data_out),
      .agg_en(agg_en), .agg_done(agg_done), .agg_address(agg_address),
      .agg_wr_en(agg_wr_en), .agg_data_out(agg_data_out),
      .qup_en(qup_en), .qup_done(qup_done), .qup_address(qup_address),
      .qup_wr_en(qup_wr_en), .qup_data_out(qup_data_out),
      .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_data_out(mem_data_out),
      .busy(busy), .done(done), .timeout_err(timeout_err), .phase(phase)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Engine stand-ins: each raises done once its enable has been high for *_lat cycles (0 = never).
   int ich_lat = 6, agg_lat = 6, qup_lat = 6;
   int ich_cnt = 0, agg_cnt = 0, qup_cnt = 0;
   bit stray_qup = 1'b0;
   initial begin
      forever begin
         @(posedge clock);
         #1;
         ich_cnt  = ich_en ? ich_cnt + 1 : 0;
         agg_cnt  = agg_en ? agg_cnt + 1 : 0;
         qup_cnt  = qup_en ? qup_cnt + 1 : 0;
         ich_done = ich_en && (ich_cnt == ich_lat);
         agg_done = agg_en && (agg_cnt == agg_lat);
         qup_done = (qup_en && (qup_cnt == qup_lat)) || stray_qup;
      end
   end

   // Reference model: phase number, cycles waited in the phase, sticky error.
   int m_phase = 0, m_wait = 0;
   bit m_terr = 1'b0;
   int np, nw;
   bit nt, eng_done;
   always @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         m_phase <= 0;
         m_wait  <= 0;
         m_terr  <= 1'b0;
      end else begin
         np = m_phase; nw = m_wait; nt = m_terr;
         eng_done = (m_phase == 1 && ich_done) || (m_phase == 2 && agg_done) ||
                    (m_phase == 3 && qup_done);
         if (m_phase == 0 || m_phase == 5) begin
            if (start) begin np = 1; nw = 0; nt = 1'b0; end
         end else if (m_phase == 4) begin
            np = 0;
         end else if (eng_done) begin
            np = (m_phase == 1) ? (ich_forAggregation ? 2 : 3) : m_phase + 1;
            nw = 0;
         end else if (m_wait == TO - 1) begin
            np = 5; nt = 1'b1;
         end else begin
            nw = m_wait + 1;
         end
         m_phase <= np;
         m_wait  <= nw;
         m_terr  <= nt;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock) begin
      check("phase", 32'(phase), 32'(m_phase));
      check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 4));
      check("done", 32'(done), 32'(m_phase == 4));
      check("ich_en", 32'(ich_en), 32'(m_phase == 1));
      check("agg_en", 32'(agg_en), 32'(m_phase == 2));
      check("qup_en", 32'(qup_en), 32'(m_phase == 3));
      check("timeout_err", 32'(timeout_err), 32'(m_terr));
      check("mem_address", 32'(mem_address), (m_phase == 1) ? 32'(ich_address) :
            (m_phase == 2) ? 32'(agg_address) : (m_phase == 3) ? 32'(qup_address) : 32'd0);
      check("mem_wr_en", 32'(mem_wr_en), (m_phase == 1) ? 32'(ich_wr_en) :
            (m_phase == 2) ? 32'(agg_wr_en) : (m_phase == 3) ? 32'(qup_wr_en) : 32'd0);
      check("mem_data_out", 32'(mem_data_out), (m_phase == 1) ? 32'(ich_data_out) :
            (m_phase == 2) ? 32'(agg_data_out) : (m_phase == 3) ? 32'(qup_data_out) : 32'd0);
   end

   // Round statistics gathered by do_round.
   int trace, last_ph, first_ph, n_ich, n_agg, n_qup, n_done;
   bit saw_terr;
   logic [10:0] mux_a;
   logic        mux_w;
   logic [15:0] mux_d;

   task automatic do_round(input int max_cyc);
      bit fin;
      trace = 0; last_ph = int'(phase); first_ph = -1;
      n_ich = 0; n_agg = 0; n_qup = 0; n_done = 0; saw_terr = 1'b0;
      fin = 1'b0;
      start = 1'b1;
      for (int k = 0; k < max_cyc && !fin; k++) begin
         @(negedge clock);
         start = 1'b0;
         if (k == 0) first_ph = int'(phase);
         if (int'(phase) != last_ph) begin
            trace   = trace * 8 + int'(phase);
            last_ph = int'(phase);
         end
         n_ich  += int'(ich_en);
         n_agg  += int'(agg_en);
         n_qup  += int'(qup_en);
         n_done += int'(done);
         if (timeout_err) saw_terr = 1'b1;
         if (phase == 3'd1) begin mux_a = mem_address; mux_w = mem_wr_en; mux_d = mem_data_out; end
         if (k > 0 && (phase == 3'd0 || phase == 3'd5)) fin = 1'b1;
      end
      check("round_completes", 32'(fin), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got no finish, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      bit reached;
      repeat (3) @(negedge clock);
      check("reset_phase", 32'(phase), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      // Aggregation path; start applied together with reset release.
      nrst = 1'b1;
      do_round(60);
      check("A_first_start", 32'(first_ph), 32'd1);
      check("A_trace", 32'(trace), 32'o12340);
      check("A_ich_cycles", 32'(n_ich), 32'd6);
      check("A_agg_cycles", 32'(n_agg), 32'd6);
      check("A_qup_cycles", 32'(n_qup), 32'd6);
      check("A_done_pulses", 32'(n_done), 32'd1);
      check("mux_ich_addr", 32'(mux_a), 32'h155);
      check("mux_ich_wr", 32'(mux_w), 32'd1);
      check("mux_ich_data", 32'(mux_d), 32'hBEEF);
      @(negedge clock);
      check("mux_idle_addr", 32'(mem_address), 32'd0);
      check("mux_idle_wr", 32'(mem_wr_en), 32'd0);
      check("mux_idle_data", 32'(mem_data_out), 32'd0);

      // No-aggregation path.
      ich_forAggregation = 1'b0;
      do_round(60);
      check("B_trace", 32'(trace), 32'o1340);
      check("B_agg_cycles", 32'(n_agg), 32'd0);
      check("B_done_pulses", 32'(n_done), 32'd1);

      // Stray qup_done during ICH, then reset in the middle of AGG.
      ich_forAggregation = 1'b1;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      stray_qup = 1'b1;
      repeat (2) @(negedge clock);
      check("stray_done_ignored", 32'(phase), 32'd1);
      stray_qup = 1'b0;
      n_done = 0;
      reached = 1'b0;
      for (int k = 0; k < 30 && !reached; k++) begin
         @(negedge clock);
         n_done += int'(done);
         if (phase == 3'd2) reached = 1'b1;
      end
      check("C_reached_agg", 32'(reached), 32'd1);
      repeat (2) @(negedge clock);
      #2 nrst = 1'b0;
      #1;
      check("arst_phase", 32'(phase), 32'd0);
      check("arst_enables", {29'd0, ich_en, agg_en, qup_en}, 32'd0);
      check("arst_busy_done_err", {29'd0, busy, done, timeout_err}, 32'd0);
      check("arst_mem", {4'd0, mem_address, mem_wr_en, mem_data_out}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         n_done += int'(done);
      end
      nrst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         n_done += int'(done);
      end
      check("C_no_done_pulse", 32'(n_done), 32'd0);

      // Timeout in QUP, sticky error, restart from ERR.
      ich_forAggregation = 1'b0;
      qup_lat = 0;
      do_round(80);
      check("D_trace", 32'(trace), 32'o135);
      check("D_qup_cycles", 32'(n_qup), 32'd16);
      check("D_done_pulses", 32'(n_done), 32'd0);
      repeat (3) @(negedge clock);
      check("D_err_sticky", 32'(timeout_err), 32'd1);
      check("D_err_phase", 32'(phase), 32'd5);
      qup_lat = 6;
      do_round(60);
      check("D_restart_trace", 32'(trace), 32'o1340);
      check("D_err_cleared", 32'(timeout_err), 32'd0);

      // Done arriving on the watchdog's final cycle.
      qup_lat = 16;
      @(negedge clock);
      do_round(80);
      check("E_trace", 32'(trace), 32'o1340);
      check("E_qup_cycles", 32'(n_qup), 32'd16);
      check("E_no_error", 32'(saw_terr), 32'd0);
      check("E_done_pulses", 32'(n_done), 32'd1);

      repeat (2) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/node_seq.md
NODE_SEQ -- requirements
Module: node_seq

Interface
REQ-001: The block SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the maximum cycles any phase may wait for its engine's done.
REQ-002: The block SHALL have port clock, input, 1 bit: single rising-edge clock.
REQ-003: The block SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-004: The block SHALL have port start, input, 1 bit: begin one round; sampled only in IDLE or ERR.
REQ-005: The block SHALL have ports ich_en (output, 1), ich_done (input, 1), ich_forAggregation (input, 1), ich_address (input, 11), ich_wr_en (input, 1) and ich_data_out (input, 16), which connect the cluster-head check engine.
REQ-006: The block SHALL have ports agg_en (output, 1), agg_done (input, 1), agg_address (input, 11), agg_wr_en (input, 1) and agg_data_out (input, 16), which connect the aggregation engine.
REQ-007: The block SHALL have ports qup_en (output, 1), qup_done (input, 1), qup_address (input, 11), qup_wr_en (input, 1) and qup_data_out (input, 16), which connect the Q-value update engine.
REQ-008: The block SHALL have ports mem_address (output, 11), mem_wr_en (output, 1) and mem_data_out (output, 16), which form the single shared port of the 2048-word x 16-bit node memory; memory read data goes directly to the engines and does not pass through this block.
REQ-009: The block SHALL have ports busy (output, 1), done (output, 1; one-cycle pulse), timeout_err (output, 1; sticky) and phase (output, 3; state encoding).

Function
REQ-010: The FSM SHALL have states IDLE=0, ICH=1, AGG=2, QUP=3, FIN=4 and ERR=5, and phase SHALL equal the current state.
REQ-011: In IDLE, start=1 SHALL cause a transition to ICH.
REQ-012: In ERR, start=1 SHALL clear timeout_err and cause a transition to ICH.
REQ-013: start SHALL be ignored in every other state.
REQ-014: In ICH, ich_done=1 SHALL latch ich_forAggregation into agg_req, then go to AGG if agg_req=1, else go to QUP.
REQ-015: In AGG, agg_done=1 SHALL cause a transition to QUP.
REQ-016: In QUP, qup_done=1 SHALL cause a transition to FIN.
REQ-017: FIN SHALL last exactly one cycle, assert done=1 and then go to IDLE.
REQ-018: Each xxx_en SHALL be registered and equal 1 exactly while the FSM is in that engine's state, including the cycle in which its done is sampled; xxx_en SHALL be 0 the cycle after that done is sampled.
REQ-019: A done input from an engine whose state is not current SHALL be ignored.
REQ-020: The memory port mux SHALL be combinational on state, forwarding address, wr_en and data_out of the active engine (ICH, AGG or QUP).
REQ-021: In IDLE, FIN and ERR, mem_address SHALL be 0, mem_wr_en SHALL be 0 and mem_data_out SHALL be 0.
REQ-022: busy SHALL be 1 in ICH, AGG, QUP and FIN, and 0 in IDLE and ERR.
REQ-023: The watchdog counter SHALL be 13 bits wide and SHALL clear on entry to each of ICH, AGG and QUP.
REQ-024: The watchdog counter SHALL increment every cycle spent in ICH, AGG or QUP.
REQ-025: When the count equals TIMEOUT_CYCLES-1 and the active engine's done=0, the FSM SHALL go to ERR and set timeout_err=1.
REQ-026: If done and the timeout occur in the same cycle, done SHALL win and no error SHALL be raised.
REQ-027: The block SHALL never assert more than one xxx_en at a time.
REQ-028: mem_wr_en SHALL never be 1 outside ICH, AGG and QUP.

Reset
REQ-029: nrst=0 SHALL immediately force state=IDLE, all xxx_en=0, done=0, busy=0, timeout_err=0, agg_req=0 and watchdog=0, regardless of the current phase.
REQ-030: Reset mid-phase SHALL abort the round with no done pulse, and the mux SHALL output zeros.
REQ-031: The first start SHALL be honoured on the first clock edge after nrst deasserts.

Structure
REQ-032: Package node_pkg SHALL hold WORD_WIDTH=16, ADDR_WIDTH=11, MEM_DEPTH=2048 and the state enum (3 bits).
REQ-033: One sub-module, phase_watchdog, SHALL be used, with inputs clear and run, parameter TIMEOUT_CYCLES, and output expired.
REQ-034: All other logic SHALL be in node_seq, with a single always block for the FSM and combinational assigns for the mux.

Verification
REQ-035: Verification SHALL cover the aggregation path: start pulse with ich_forAggregation=1 and each engine giving done after 5 cycles -> phase 1,2,3,4,0; one done pulse; each en high for exactly 6 cycles.
REQ-036: Verification SHALL cover the no-aggregation path: ich_forAggregation=0 -> AGG skipped; agg_en never 1; phase goes 1 to 3 directly.
REQ-037: Verification SHALL cover the mux: ich_address=0x155, ich_wr_en=1, ich_data_out=0xBEEF in ICH -> mem_* equal those values; in IDLE -> 0, 0, 0.
REQ-038: Verification SHALL cover timeout: TIMEOUT_CYCLES=16 and qup_done held 0 -> ERR entered 16 cycles after QUP entry; timeout_err=1 until next start; a new start restarts ICH.
REQ-039: Verification SHALL cover reset and stray done: nrst pulsed low in AGG -> all outputs 0 asynchronously with no done pulse; qup_done=1 during ICH -> ignored.
REQ-040: Verification SHALL cover the done/timeout tie: done arriving in the same cycle as watchdog expiry -> normal advance with timeout_err=0.
